// File: rtl/text_writer_pkg.sv
// text_writer_pkg: shared constants for the 80x30 text buffer write path.
//   Geometry (NCOL, NROW, COL_W, ROW_W), clear code BLANK, the control
//   codes the writer interprets and the writer state encoding.
package text_writer_pkg;

   localparam int NCOL  = 80;
   localparam int NROW  = 30;
   localparam int COL_W = 7;
   localparam int ROW_W = 5;

   localparam logic [6:0]       BLANK    = 7'h20;
   localparam logic [COL_W-1:0] COL_LAST = COL_W'(NCOL - 1);
   localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(NROW - 1);

   localparam logic [7:0] CC_BS  = 8'h08;
   localparam logic [7:0] CC_TAB = 8'h09;
   localparam logic [7:0] CC_LF  = 8'h0A;
   localparam logic [7:0] CC_FF  = 8'h0C;
   localparam logic [7:0] CC_CR  = 8'h0D;

   typedef enum logic [1:0] {
      ST_INIT       = 2'd0,
      ST_IDLE       = 2'd1,
      ST_CLR_LINE   = 2'd2,
      ST_CLR_SCREEN = 2'd3
   } tw_state_t;

endpackage

// File: rtl/text_writer_if.sv
// text_writer_if: byte stream handshake into the text writer.
//   char_valid - source holds a byte on char_data
//   char_data  - incoming byte
//   char_ready - writer accepts a byte this cycle
//   master: byte source, slave: text writer.
interface text_writer_if;
   logic       char_valid;
   logic [7:0] char_data;
   logic       char_ready;

   modport master (output char_valid, output char_data, input char_ready);
   modport slave  (input char_valid, input char_data, output char_ready);
endinterface

// File: rtl/text_writer_clear_sweep.sv
// text_writer_clear_sweep: column/row counter used to blank buffer cells.
//   clk, rstn   - clock, synchronous active-low reset (counter -> (0,0), full)
//   start       - load: col=0, row = start_full ? 0 : start_row
//   start_full  - whole-screen sweep when 1, single row when 0
//   start_row   - row to sweep in single-row mode
//   run         - advance one cell
//   col, row    - current cell
//   last        - current cell is the final cell of the sweep
module text_writer_clear_sweep
   import text_writer_pkg::*;
(
   input  logic             clk,
   input  logic             rstn,
   input  logic             start,
   input  logic             start_full,
   input  logic [ROW_W-1:0] start_row,
   input  logic             run,
   output logic [COL_W-1:0] col,
   output logic [ROW_W-1:0] row,
   output logic             last
);

   logic full;

   // Reset leaves the counter primed for the whole-screen sweep out of reset.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         col  <= '0;
         row  <= '0;
         full <= 1'b1;
      end else if (start) begin
         col  <= '0;
         row  <= start_full ? '0 : start_row;
         full <= start_full;
      end else if (run) begin
         if (col == COL_LAST) begin
            col <= '0;
            if (full) row <= (row == ROW_LAST) ? '0 : row + 1'b1;
         end else begin
            col <= col + 1'b1;
         end
      end
   end

   assign last = (col == COL_LAST) && (!full || (row == ROW_LAST));

endmodule

// File: rtl/text_writer.sv
// text_writer: write-side front end of the 80x30 character buffer.
//   Consumes bytes over chr (valid/ready), keeps a cursor, writes printable
//   ASCII and interprets CR, LF, BS and FF. Owns the buffer write port.
//   clk, rstn          - clock, synchronous active-low reset
//   chr                - byte stream (slave side)
//   wr_en/col_w/row_w/din - registered buffer write port
//   cursor_col/row     - current cursor
//   busy               - a clear sweep is in progress
//   Optional: define TEXT_WRITER_TAB_EN to make 0x09 advance to the next
//   multiple of 8; otherwise 0x09 is ignored.
//
//   state          | meaning
//   ST_INIT        | post-reset blank of all 2400 cells
//   ST_IDLE        | ready for a byte
//   ST_CLR_LINE    | blanking the row the cursor just advanced onto
//   ST_CLR_SCREEN  | form feed: blanking all cells, cursor at (0,0)
module text_writer
   import text_writer_pkg::*;
(
   input  logic             clk,
   input  logic             rstn,
   text_writer_if.slave     chr,
   output logic             wr_en,
   output logic [COL_W-1:0] col_w,
   output logic [ROW_W-1:0] row_w,
   output logic [6:0]       din,
   output logic [COL_W-1:0] cursor_col,
   output logic [ROW_W-1:0] cursor_row,
   output logic             busy
);

   tw_state_t        state, state_d;
   logic             wr_en_d;
   logic [COL_W-1:0] col_w_d, cur_col_d;
   logic [ROW_W-1:0] row_w_d, cur_row_d;
   logic [6:0]       din_d;
   logic             accept, adv;
   logic             sw_start, sw_full, sw_run, sw_last;
   logic [ROW_W-1:0] sw_row_in, sw_row;
   logic [COL_W-1:0] sw_col;

`ifdef TEXT_WRITER_TAB_EN
   logic [COL_W:0] tab_col;
   assign tab_col = {1'b0, cursor_col & ~COL_W'(7)} + (COL_W+1)'(8);
`endif

   text_writer_clear_sweep u_sweep (
      .clk        (clk),
      .rstn       (rstn),
      .start      (sw_start),
      .start_full (sw_full),
      .start_row  (sw_row_in),
      .run        (sw_run),
      .col        (sw_col),
      .row        (sw_row),
      .last       (sw_last)
   );

   assign chr.char_ready = (state == ST_IDLE);
   assign busy           = (state != ST_IDLE);
   assign accept         = chr.char_valid && (state == ST_IDLE);

   always_ff @(posedge clk) begin
      if (!rstn) begin
         state      <= ST_INIT;
         wr_en      <= 1'b0;
         col_w      <= '0;
         row_w      <= '0;
         din        <= '0;
         cursor_col <= '0;
         cursor_row <= '0;
      end else begin
         state      <= state_d;
         wr_en      <= wr_en_d;
         col_w      <= col_w_d;
         row_w      <= row_w_d;
         din        <= din_d;
         cursor_col <= cur_col_d;
         cursor_row <= cur_row_d;
      end
   end

   always_comb begin
      state_d   = state;
      wr_en_d   = 1'b0;
      col_w_d   = col_w;
      row_w_d   = row_w;
      din_d     = din;
      cur_col_d = cursor_col;
      cur_row_d = cursor_row;
      sw_start  = 1'b0;
      sw_full   = 1'b0;
      sw_row_in = '0;
      sw_run    = 1'b0;
      adv       = 1'b0;

      case (state)
         ST_INIT, ST_CLR_LINE, ST_CLR_SCREEN: begin
            sw_run  = 1'b1;
            wr_en_d = 1'b1;
            col_w_d = sw_col;
            row_w_d = sw_row;
            din_d   = BLANK;
            if (sw_last) state_d = ST_IDLE;
         end
         ST_IDLE: begin
            if (accept) begin
               if (chr.char_data >= 8'h20 && chr.char_data <= 8'h7E) begin
                  wr_en_d = 1'b1;
                  col_w_d = cursor_col;
                  row_w_d = cursor_row;
                  din_d   = chr.char_data[6:0];
                  if (cursor_col == COL_LAST) begin
                     cur_col_d = '0;
                     adv       = 1'b1;
                  end else begin
                     cur_col_d = cursor_col + 1'b1;
                  end
               end else begin
                  case (chr.char_data)
                     CC_CR: cur_col_d = '0;
                     CC_LF: begin
                        cur_col_d = '0;
                        adv       = 1'b1;
                     end
                     CC_BS: begin
                        if (cursor_col != '0) begin
                           cur_col_d = cursor_col - 1'b1;
                           wr_en_d   = 1'b1;
                           col_w_d   = cursor_col - 1'b1;
                           row_w_d   = cursor_row;
                           din_d     = BLANK;
                        end
                     end
                     CC_FF: begin
                        state_d   = ST_CLR_SCREEN;
                        sw_start  = 1'b1;
                        sw_full   = 1'b1;
                        cur_col_d = '0;
                        cur_row_d = '0;
                     end
`ifdef TEXT_WRITER_TAB_EN
                     CC_TAB: begin
                        if (tab_col >= (COL_W+1)'(NCOL)) begin
                           cur_col_d = '0;
                           adv       = 1'b1;
                        end else begin
                           cur_col_d = tab_col[COL_W-1:0];
                        end
                     end
`endif
                     default: ;
                  endcase
               end
               // No scrolling: wrap to the top and blank the destination row.
               if (adv) begin
                  cur_row_d = (cursor_row == ROW_LAST) ? '0 : cursor_row + 1'b1;
                  sw_start  = 1'b1;
                  sw_row_in = cur_row_d;
                  state_d   = ST_CLR_LINE;
               end
            end
         end
         default: state_d = ST_INIT;
      endcase
   end

endmodule

// File: tb/tb_text_writer.sv
module tb_text_writer;
   import text_writer_pkg::*;

   logic clk = 1'b0;
   logic rstn = 1'b0;
   always #5 clk = ~clk;

   text_writer_if chr();

   logic             wr_en;
   logic [COL_W-1:0] col_w, cursor_col;
   logic [ROW_W-1:0] row_w, cursor_row;
   logic [6:0]       din;
   logic             busy;

   text_writer dut (
      .clk        (clk),
      .rstn       (rstn),
      .chr        (chr),
      .wr_en      (wr_en),
      .col_w      (col_w),
      .row_w      (row_w),
      .din        (din),
      .cursor_col (cursor_col),
      .cursor_row (cursor_row),
      .busy       (busy)
   );

   typedef struct packed {
      logic [COL_W-1:0] c;
      logic [ROW_W-1:0] r;
      logic [6:0]       d;
   } wr_t;

   wr_t sb[$];
   int  n_checks = 0;
   int  n_pass   = 0;

   function automatic void push(int c, int r, logic [6:0] d);
      wr_t e;
      e.c = COL_W'(c);
      e.r = ROW_W'(r);
      e.d = d;
      sb.push_back(e);
   endfunction

   function automatic void push_row(int r);
      for (int c = 0; c < NCOL; c++) push(c, r, BLANK);
   endfunction

   function automatic void push_full();
      for (int r = 0; r < NROW; r++) push_row(r);
   endfunction

   // Scoreboard: every observed write must be the next expected one.
   always @(negedge clk) begin
      wr_t act;
      wr_t exp;
      if (rstn === 1'b1 && wr_en === 1'b1) begin
         act.c = col_w;
         act.r = row_w;
         act.d = din;
         n_checks++;
         if (sb.size() == 0) begin
            $display("FAIL unexpected_write col=%0d row=%0d din=%h, required no write",
                     col_w, row_w, din);
         end else begin
            exp = sb.pop_front();
            if (act !== exp)
               $display("FAIL write got (%0d,%0d)=%h required (%0d,%0d)=%h",
                        act.c, act.r, act.d, exp.c, exp.r, exp.d);
            else
               n_pass++;
         end
      end
   end

   // Present a byte and return at the negedge right after it was accepted.
   task automatic send_byte(input logic [7:0] b);
      int t = 0;
      @(negedge clk);
      chr.char_valid = 1'b1;
      chr.char_data  = b;
      while (chr.char_ready !== 1'b1 && t < 5000) begin
         @(negedge clk);
         t++;
      end
      if (t >= 5000) begin
         n_checks++;
         $display("FAIL send_timeout byte=%h char_ready never rose", b);
      end
      @(negedge clk);
      chr.char_valid = 1'b0;
   endtask

   // Count negedges until char_ready is seen high.
   task automatic wait_ready(output int low);
      low = 0;
      while (chr.char_ready !== 1'b1 && low < 5000) begin
         @(negedge clk);
         low++;
      end
      if (low >= 5000) begin
         n_checks++;
         $display("FAIL ready_timeout char_ready low for %0d cycles", low);
      end
   endtask

   task automatic do_lf(input int r);
      int low;
      push_row(r);
      send_byte(CC_LF);
      wait_ready(low);
   endtask

   task automatic test_reset;
      int low;
      rstn = 1'b0;
      chr.char_valid = 1'b0;
      chr.char_data  = 8'h00;
      repeat (3) @(negedge clk);
      n_checks++; if ({wr_en, col_w, row_w, din} !== '0) $display("FAIL rst_write got %b_%0d_%0d_%h required all 0", wr_en, col_w, row_w, din); else n_pass++;
      n_checks++; if ({cursor_col, cursor_row} !== '0) $display("FAIL rst_cursor got (%0d,%0d) required (0,0)", cursor_col, cursor_row); else n_pass++;
      n_checks++; if (chr.char_ready !== 1'b0) $display("FAIL rst_ready got %b required 0", chr.char_ready); else n_pass++;
      n_checks++; if (busy !== 1'b1) $display("FAIL rst_busy got %b required 1", busy); else n_pass++;
      sb.delete();
      push_full();
      rstn = 1'b1;
      wait_ready(low);
      n_checks++; if (low != 2400) $display("FAIL init_ready_low got %0d required 2400", low); else n_pass++;
      @(negedge clk);
      n_checks++; if (sb.size() != 0) $display("FAIL init_writes_left got %0d required 0", sb.size()); else n_pass++;
      n_checks++; if ({cursor_col, cursor_row} !== '0) $display("FAIL init_cursor got (%0d,%0d) required (0,0)", cursor_col, cursor_row); else n_pass++;
      n_checks++; if (busy !== 1'b0 || chr.char_ready !== 1'b1) $display("FAIL init_idle got busy=%b ready=%b required 0/1", busy, chr.char_ready); else n_pass++;
   endtask

   task automatic test_print;
      push(0, 0, 7'h48);
      send_byte(8'h48);
      n_checks++; if (wr_en !== 1'b1) $display("FAIL print_latency_H got wr_en=%b required 1", wr_en); else n_pass++;
      n_checks++; if (cursor_col !== 7'd1 || cursor_row !== 5'd0) $display("FAIL print_cursor_H got (%0d,%0d) required (1,0)", cursor_col, cursor_row); else n_pass++;
      push(1, 0, 7'h69);
      send_byte(8'h69);
      n_checks++; if (wr_en !== 1'b1) $display("FAIL print_latency_i got wr_en=%b required 1", wr_en); else n_pass++;
      n_checks++; if (cursor_col !== 7'd2 || cursor_row !== 5'd0) $display("FAIL print_cursor_i got (%0d,%0d) required (2,0)", cursor_col, cursor_row); else n_pass++;
      @(negedge clk);
      n_checks++; if (sb.size() != 0) $display("FAIL print_writes_left got %0d required 0", sb.size()); else n_pass++;
   endtask

   task automatic test_wrap;
      int low;
      for (int r = 1; r <= 3; r++) do_lf(r);
      for (int c = 0; c < 79; c++) begin
         push(c, 3, 7'h78);
         send_byte(8'h78);
      end
      n_checks++; if (cursor_col !== 7'd79 || cursor_row !== 5'd3) $display("FAIL wrap_pre got (%0d,%0d) required (79,3)", cursor_col, cursor_row); else n_pass++;
      push(79, 3, 7'h41);
      push_row(4);
      send_byte(8'h41);
      n_checks++; if (cursor_col !== 7'd0 || cursor_row !== 5'd4) $display("FAIL wrap_cursor got (%0d,%0d) required (0,4)", cursor_col, cursor_row); else n_pass++;
      wait_ready(low);
      n_checks++; if (low != 80) $display("FAIL wrap_ready_low got %0d required 80", low); else n_pass++;
      for (int r = 5; r <= 29; r++) do_lf(r);
      for (int c = 0; c < 79; c++) begin
         push(c, 29, 7'h78);
         send_byte(8'h78);
      end
      push(79, 29, 7'h41);
      push_row(0);
      send_byte(8'h41);
      n_checks++; if (cursor_col !== 7'd0 || cursor_row !== 5'd0) $display("FAIL wrap_top got (%0d,%0d) required (0,0)", cursor_col, cursor_row); else n_pass++;
      wait_ready(low);
      n_checks++; if (low != 80) $display("FAIL wrap_top_ready_low got %0d required 80", low); else n_pass++;
      @(negedge clk);
      n_checks++; if (sb.size() != 0) $display("FAIL wrap_writes_left got %0d required 0", sb.size()); else n_pass++;
   endtask

   task automatic test_controls;
      logic [7:0] ch;
      do_lf(1);
      do_lf(2);
      for (int c = 0; c < 5; c++) begin
         ch = 8'h61 + 8'(c);
         push(c, 2, ch[6:0]);
         send_byte(ch);
      end
      push(4, 2, BLANK);
      send_byte(CC_BS);
      n_checks++; if (wr_en !== 1'b1) $display("FAIL bs_write got wr_en=%b required 1", wr_en); else n_pass++;
      n_checks++; if (cursor_col !== 7'd4 || cursor_row !== 5'd2) $display("FAIL bs_cursor got (%0d,%0d) required (4,2)", cursor_col, cursor_row); else n_pass++;
      send_byte(CC_CR);
      n_checks++; if (cursor_col !== 7'd0 || cursor_row !== 5'd2 || wr_en !== 1'b0) $display("FAIL cr got (%0d,%0d) wr_en=%b required (0,2) 0", cursor_col, cursor_row, wr_en); else n_pass++;
      send_byte(CC_BS);
      n_checks++; if (cursor_col !== 7'd0 || cursor_row !== 5'd2 || wr_en !== 1'b0) $display("FAIL bs_col0 got (%0d,%0d) wr_en=%b required (0,2) 0", cursor_col, cursor_row, wr_en); else n_pass++;
      send_byte(8'h07);
      send_byte(8'h7F);
      send_byte(8'hC1);
      n_checks++; if (cursor_col !== 7'd0 || cursor_row !== 5'd2 || wr_en !== 1'b0) $display("FAIL ignored got (%0d,%0d) wr_en=%b required (0,2) 0", cursor_col, cursor_row, wr_en); else n_pass++;
      for (int c = 0; c < 5; c++) begin
         push(c, 2, 7'h62);
         send_byte(8'h62);
      end
      @(negedge clk);
      n_checks++; if (sb.size() != 0) $display("FAIL ctrl_writes_left got %0d required 0", sb.size()); else n_pass++;
   endtask

   task automatic test_tab;
      int low;
      send_byte(CC_TAB);
`ifdef TEXT_WRITER_TAB_EN
      n_checks++; if (cursor_col !== 7'd8 || wr_en !== 1'b0) $display("FAIL tab5 got col=%0d wr_en=%b required 8 0", cursor_col, wr_en); else n_pass++;
      send_byte(CC_TAB);
      n_checks++; if (cursor_col !== 7'd16) $display("FAIL tab8 got col=%0d required 16", cursor_col); else n_pass++;
      for (int c = 16; c < 79; c++) begin
         push(c, 2, 7'h63);
         send_byte(8'h63);
      end
      push_row(3);
      send_byte(CC_TAB);
      n_checks++; if (cursor_col !== 7'd0 || cursor_row !== 5'd3) $display("FAIL tab79 got (%0d,%0d) required (0,3)", cursor_col, cursor_row); else n_pass++;
      wait_ready(low);
      n_checks++; if (low != 80) $display("FAIL tab79_ready_low got %0d required 80", low); else n_pass++;
`else
      n_checks++; if (cursor_col !== 7'd5 || cursor_row !== 5'd2 || wr_en !== 1'b0) $display("FAIL tab_off got (%0d,%0d) wr_en=%b required (5,2) 0", cursor_col, cursor_row, wr_en); else n_pass++;
`endif
      @(negedge clk);
      n_checks++; if (sb.size() != 0) $display("FAIL tab_writes_left got %0d required 0", sb.size()); else n_pass++;
   endtask

   task automatic test_ff;
      int low;
`ifdef TEXT_WRITER_TAB_EN
      push(0, 3, 7'h7A);
`else
      push(5, 2, 7'h7A);
`endif
      send_byte(8'h7A);
      push_full();
      send_byte(CC_FF);
      n_checks++; if (cursor_col !== 7'd0 || cursor_row !== 5'd0) $display("FAIL ff_cursor got (%0d,%0d) required (0,0)", cursor_col, cursor_row); else n_pass++;
      n_checks++; if (busy !== 1'b1 || wr_en !== 1'b0) $display("FAIL ff_start got busy=%b wr_en=%b required 1 0", busy, wr_en); else n_pass++;
      wait_ready(low);
      n_checks++; if (low != 2400) $display("FAIL ff_ready_low got %0d required 2400", low); else n_pass++;
      @(negedge clk);
      n_checks++; if (sb.size() != 0) $display("FAIL ff_writes_left got %0d required 0", sb.size()); else n_pass++;
   endtask

   task automatic test_reset_mid;
      int t = 0;
      int low;
      push(0, 0, 7'h51);
      send_byte(8'h51);
      push_full();
      send_byte(CC_FF);
      while (sb.size() > 2300 && t < 5000) begin
         @(negedge clk);
         t++;
      end
      n_checks++; if (sb.size() != 2300) $display("FAIL mid_progress got %0d left required 2300", sb.size()); else n_pass++;
      rstn = 1'b0;
      @(negedge clk);
      n_checks++; if ({wr_en, col_w, row_w, din} !== '0) $display("FAIL mid_rst_write got %b_%0d_%0d_%h required all 0", wr_en, col_w, row_w, din); else n_pass++;
      n_checks++; if (busy !== 1'b1 || chr.char_ready !== 1'b0) $display("FAIL mid_rst_flags got busy=%b ready=%b required 1 0", busy, chr.char_ready); else n_pass++;
      sb.delete();
      @(negedge clk);
      push_full();
      rstn = 1'b1;
      wait_ready(low);
      n_checks++; if (low != 2400) $display("FAIL mid_init_low got %0d required 2400", low); else n_pass++;
      @(negedge clk);
      n_checks++; if (sb.size() != 0) $display("FAIL mid_writes_left got %0d required 0", sb.size()); else n_pass++;
      n_checks++; if ({cursor_col, cursor_row} !== '0) $display("FAIL mid_cursor got (%0d,%0d) required (0,0)", cursor_col, cursor_row); else n_pass++;
   endtask

   initial begin
      chr.char_valid = 1'b0;
      chr.char_data  = 8'h00;
      test_reset();
      test_print();
      test_wrap();
      test_controls();
      test_tab();
      test_ff();
      test_reset_mid();
      repeat (3) @(negedge clk);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #3_000_000;
      $display("FAIL watchdog simulation did not complete");
      $display("%0d/%0d checks passed", n_pass, n_checks + 1);
      $fatal(1);
   end

endmodule
